// File: rtl/ras_ctrl.sv
// Return-address stack for fetch-stage jalr prediction.
// Circular stack with saturating occupancy and one-deep undo of the most
// recent push/pop when the instruction that caused it is flushed.
module ras_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       push,
  input  logic [31:0]                push_addr,
  input  logic                       pop,
  input  logic                       rollback_push,
  input  logic                       rollback_pop,
  output logic [31:0]                top_addr,
  output logic                       top_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      mem_reg [DEPTH];
  logic [PTR_W-1:0] tp_reg, tp_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      shadow_reg, shadow_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [DEPTH-1:0] wr_sel;

  logic [PTR_W-1:0] tp_inc, tp_dec;
  logic             empty, full;

  assign tp_inc = tp_reg + 1'b1;
  assign tp_dec = tp_reg - 1'b1;
  assign empty  = (count_reg == '0);
  assign full   = (count_reg == FULL_CNT);

  // Next-state decode: rollback outranks push/pop, stall only gates push/pop.
  always_comb begin
    tp_next        = tp_reg;
    count_next     = count_reg;
    shadow_next    = shadow_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = tp_reg;
    wr_data        = push_addr;

    if (rollback_push && rollback_pop) begin
      // Undo a push+pop: restore the entry that was replaced in place.
      wr_en   = 1'b1;
      wr_idx  = tp_reg;
      wr_data = shadow_reg;
    end else if (rollback_push) begin
      if (!empty) begin
        tp_next    = tp_dec;
        count_next = count_reg - 1'b1;
      end
    end else if (rollback_pop) begin
      // Re-push the last popped address; saturates silently when full.
      wr_en   = 1'b1;
      wr_idx  = tp_inc;
      wr_data = shadow_reg;
      tp_next = tp_inc;
      if (!full) begin
        count_next = count_reg + 1'b1;
      end
    end else if (!stall) begin
      if (push && pop && !empty) begin
        // Return-and-call: swap the top entry, remembering the old one.
        shadow_next = mem_reg[tp_reg];
        wr_en       = 1'b1;
        wr_idx      = tp_reg;
      end else if (push) begin
        // Plain push, or push+pop on an empty stack (which also underflows).
        wr_en          = 1'b1;
        wr_idx         = tp_inc;
        tp_next        = tp_inc;
        underflow_next = pop;
        if (full) begin
          overflow_next = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else if (pop) begin
        if (empty) begin
          underflow_next = 1'b1;
        end else begin
          shadow_next = mem_reg[tp_reg];
          tp_next     = tp_dec;
          count_next  = count_reg - 1'b1;
        end
      end
    end
  end

  // One-hot write select per stack entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (wr_idx == PTR_W'(gi));
  end

  // Stack storage; cleared on reset so an empty stack reads as zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        mem_reg[i] <= wr_data;
      end
    end
  end

  // Pointer, occupancy, undo shadow and event pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_reg        <= '0;
      count_reg     <= '0;
      shadow_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      tp_reg        <= tp_next;
      count_reg     <= count_next;
      shadow_reg    <= shadow_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign top_addr  = mem_reg[tp_reg];
  assign top_valid = !empty;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: LIFO order, overflow/underflow, stall and rollback.
module tb_ras_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             push;
  logic [31:0]      push_addr;
  logic             pop;
  logic             rollback_push;
  logic             rollback_pop;
  logic [31:0]      top_addr;
  logic             top_valid;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  int vectors = 0;
  int miscompares = 0;

  ras_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .push          (push),
    .push_addr     (push_addr),
    .pop           (pop),
    .rollback_push (rollback_push),
    .rollback_pop  (rollback_pop),
    .top_addr      (top_addr),
    .top_valid     (top_valid),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Apply one cycle of strobes, then sample 1 ns after the edge.
  task automatic cyc(input logic p, input logic [31:0] a, input logic o,
                     input logic rbp, input logic rbo, input logic s);
    push = p; push_addr = a; pop = o;
    rollback_push = rbp; rollback_pop = rbo; stall = s;
    @(posedge clk);
    #1;
    push = 1'b0; push_addr = '0; pop = 1'b0;
    rollback_push = 1'b0; rollback_pop = 1'b0; stall = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp_top, input int exp_cnt);
    chk({tag, ".top"}, top_addr, exp_top);
    chk({tag, ".cnt"}, 32'(count), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 0; push = 0; push_addr = 0; pop = 0;
    rollback_push = 0; rollback_pop = 0;

    // Reset then idle
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    chk_state("rst", 32'h0, 0);
    chk("rst.valid", 32'(top_valid), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.udf", 32'(underflow), 0);

    // LIFO order
    cyc(1, 32'h100, 0, 0, 0, 0);
    chk_state("lifo.push1", 32'h100, 1);
    cyc(1, 32'h200, 0, 0, 0, 0);
    cyc(1, 32'h300, 0, 0, 0, 0);
    chk_state("lifo.push3", 32'h300, 3);
    chk("lifo.valid", 32'(top_valid), 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk_state("lifo.pop1", 32'h200, 2);
    cyc(0, 0, 1, 0, 0, 0);
    chk_state("lifo.pop2", 32'h100, 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("lifo.pop3.cnt", 32'(count), 0);
    chk("lifo.pop3.valid", 32'(top_valid), 0);
    chk("lifo.pop3.udf", 32'(underflow), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("lifo.pop4.udf", 32'(underflow), 1);
    chk("lifo.pop4.cnt", 32'(count), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lifo.idle.udf", 32'(underflow), 0);

    // Overflow: nine pushes into an eight-entry stack
    for (int i = 0; i < 9; i++) begin
      cyc(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
      if (i == 7) begin
        chk("ovf.push8.ovf", 32'(overflow), 0);
        chk("ovf.push8.cnt", 32'(count), 8);
      end
    end
    chk("ovf.push9.ovf", 32'(overflow), 1);
    chk_state("ovf.push9", 32'h1020, 8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ovf.idle.ovf", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf.top%0d", k), top_addr, 32'h1020 - 32'(4 * k));
      cyc(0, 0, 1, 0, 0, 0);
      chk($sformatf("ovf.cnt%0d", k), 32'(count), 32'(7 - k));
    end
    chk("ovf.pop8.udf", 32'(underflow), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ovf.pop9.udf", 32'(underflow), 1);

    // Stall gating
    cyc(1, 32'h20, 0, 0, 0, 0);
    cyc(1, 32'h40, 0, 0, 0, 0);
    chk_state("stall.pre", 32'h40, 2);
    cyc(1, 32'h80, 0, 0, 0, 1);
    chk_state("stall.push", 32'h40, 2);
    cyc(0, 0, 1, 0, 0, 1);
    chk_state("stall.pop", 32'h40, 2);
    chk("stall.pop.udf", 32'(underflow), 0);
    cyc(1, 32'h80, 1, 0, 0, 1);
    chk_state("stall.both", 32'h40, 2);
    cyc(1, 32'h80, 0, 0, 0, 0);
    chk_state("stall.release", 32'h80, 3);

    // Rollback of a push
    cyc(1, 32'hA0, 0, 0, 0, 0);
    chk_state("rbpush.push", 32'hA0, 4);
    cyc(0, 0, 0, 1, 0, 0);
    chk_state("rbpush.undo", 32'h80, 3);

    // Rollback of a pop
    cyc(1, 32'hB0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk_state("rbpop.pop", 32'h80, 3);
    cyc(0, 0, 0, 0, 1, 0);
    chk_state("rbpop.undo", 32'hB0, 4);

    // Rollback wins over a same-cycle push
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 32'hDEAD, 0, 0, 1, 0);
    chk_state("rbprio.undo", 32'hB0, 4);
    chk("rbprio.ovf", 32'(overflow), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk_state("rbprio.pop", 32'h80, 3);

    // Push+pop combo and its undo
    do_reset();
    cyc(1, 32'h10, 0, 0, 0, 0);
    cyc(1, 32'h20, 0, 0, 0, 0);
    cyc(1, 32'h30, 1, 0, 0, 0);
    chk_state("combo.swap", 32'h30, 2);
    chk("combo.swap.udf", 32'(underflow), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk_state("combo.undo", 32'h20, 2);
    cyc(0, 0, 1, 0, 0, 0);
    chk_state("combo.pop", 32'h10, 1);

    // Push+pop on an empty stack acts as push and underflows
    cyc(0, 0, 1, 0, 0, 0);
    chk("empty.cnt", 32'(count), 0);
    cyc(1, 32'h44, 1, 0, 0, 0);
    chk_state("empty.combo", 32'h44, 1);
    chk("empty.combo.udf", 32'(underflow), 1);

    // Rollback is honoured even while stalled
    cyc(0, 0, 0, 1, 0, 1);
    chk("rbstall.cnt", 32'(count), 0);
    chk("rbstall.valid", 32'(top_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller for the fetch stage. It consumes the mini-control ras_push/ras_pop/ras_rollback_push/ras_rollback_pop strobes and the fetch-stage pc+4.
- It supplies the predicted jalr return target to the jalr prediction path.
- It manages a circular stack with saturating occupancy and single-level speculative undo for the instruction squashed by a pipeline flush.

Parameters:
DEPTH, 8, number of stack entries; power of two, minimum 2.
PTR_W, $clog2(DEPTH), stack pointer width (derived, not overridable).
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  pipeline stall; gates push/pop only
push  input  1  call detected in fetch: push push_addr
push_addr  input  32  return address (fetch pc+4)
pop  input  1  return detected in fetch: pop top entry
rollback_push  input  1  undo most recent push (instruction flushed)
rollback_pop  input  1  undo most recent pop (instruction flushed)
top_addr  output  32  current top entry (combinational read of mem[tp]); jalr prediction target
top_valid  output  1  count != 0
count  output  CNT_W  number of valid entries, 0..DEPTH
overflow  output  1  registered one-cycle pulse: previous cycle's push overwrote the oldest entry
underflow  output  1  registered one-cycle pulse: previous cycle's pop found the stack empty

Behaviour:
- State: mem[0..DEPTH-1] x 32, top pointer tp (PTR_W), count (CNT_W), shadow (32, last popped address), overflow/underflow regs.
- Reset (rst=1 at clk edge): tp=0, count=0, shadow=0, all mem=0, overflow=0, underflow=0. Result: top_addr=0, top_valid=0.
- Pointer arithmetic is modulo DEPTH (natural wrap of PTR_W bits).
- Priority: rst > rollback (either) > push/pop. Any rollback strobe in a cycle ignores push/pop that cycle, including when stall=1.
- When rollback is inactive and stall=1: push/pop are ignored and the state is held.
- Push only (push=1, pop=0):
  - mem[tp+1] <= push_addr; tp <= tp+1.
  - count <= count+1 when count<DEPTH.
  - When count==DEPTH: count holds, the oldest entry is overwritten, overflow <= 1.
- Pop only (pop=1, push=0):
  - When count>0: shadow <= mem[tp]; tp <= tp-1; count <= count-1.
  - When count==0: no state change, underflow <= 1.
- Push+pop (jalr acting as both return and call):
  - When count>0: shadow <= mem[tp]; mem[tp] <= push_addr; tp and count unchanged.
  - When count==0: behaves as push only, and underflow <= 1.
- rollback_push only:
  - When count>0: tp <= tp-1; count <= count-1. Entry contents are left stale.
  - When count==0: ignored.
- rollback_pop only:
  - mem[tp+1] <= shadow; tp <= tp+1.
  - count <= count+1, saturating at DEPTH (at DEPTH the oldest entry is overwritten; no overflow pulse).
- Both rollback strobes together (undo of push+pop): mem[tp] <= shadow; tp and count unchanged.
- overflow/underflow are 0 in every cycle not immediately following a qualifying event. They never assert in a cycle where rollback had priority.
- Undo depth is exactly one operation. Mini-control guarantees that a rollback refers to the most recent unstalled push/pop; other sequences are undefined.
- Latency: all updates are visible on top_addr/count the cycle after the edge. top_addr is not bypassed from the same-cycle push.

Test Plan:
- Reset then idle: rst=1 two cycles, release -> count=0, top_valid=0, top_addr=0, overflow=underflow=0.
- LIFO: push 0x100, 0x200, 0x300 on consecutive cycles, then pop x3 -> top_addr 0x300, 0x200, 0x100, and count 3,2,1,0 after each pop; a 4th pop gives underflow=1 for one cycle, count stays 0.
- Overflow (DEPTH=8): push 0x1000+4*i for i=0..8 -> overflow pulses once after the 9th push, count=8, top_addr=0x1020. Eight pops return 0x1020 down to 0x1004; the 9th pop underflows.
- Stall gating: with count=2, top 0x40, hold stall=1 while pulsing push 0x80 and pop -> state unchanged. The same push with stall=0 -> top 0x80, count=3.
- Rollback:
  - Push 0xA0 then rollback_push -> top back to the prior entry, count restored.
  - Pop (top 0xB0) then rollback_pop -> top_addr=0xB0, count restored.
  - rollback_pop with push=1 in the same cycle -> push ignored.
- Push+pop combo: stack [0x10, 0x20(top)], push=pop=1 with push_addr 0x30 -> top 0x30, count 2. Then both rollbacks together -> top 0x20, count 2. Then pop -> 0x10.
